text_engine: RTL and testbench

TEXT_ENGINE -- requirements
Module: text_engine

---
 rtl/text_engine.sv | 118 +++++++++++
 tb/tb_text_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_engine.sv
// Text-mode pixel engine: maps an OLED byte address to a glyph column byte via text store and font ROM.
// Optional TEXT_ENGINE_INVERT_EN adds an invert input that complements the delivered byte.
module text_engine (
    input  logic        clk,
    input  logic        rst,
`ifdef TEXT_ENGINE_INVERT_EN
    input  logic        invert,
`endif
    input  logic [9:0]  pixelAddress,
    input  logic        reqValid,
    output logic        busy,
    output logic [5:0]  charAddress,
    input  logic [7:0]  charOutput,
    output logic [10:0] fontAddress,
    output logic        fontRead,
    input  logic [7:0]  fontByte,
    output logic [7:0]  pixelData,
    output logic        pixelValid
);

    localparam int unsigned AddrW     = 10;
    localparam int unsigned ByteW     = 8;
    localparam int unsigned GlyphW    = 7;
    localparam int unsigned FontAddrW = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHAR  = 2'd1,
        FONT  = 2'd2,
        LATCH = 2'd3
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic               accept;
    logic [AddrW-1:0]   addrQ;
    logic               printableQ;
    logic               invertQ;
    logic               charPrintable;
    logic [GlyphW-1:0]  glyph;
    logic [ByteW-1:0]   fontSel;
    logic [ByteW-1:0]   pixelNext;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: one fixed pass through CHAR/FONT/LATCH per accepted request
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    stateNext = CHAR;
                    accept    = 1'b1;
                end
            end
            CHAR:    stateNext = FONT;
            FONT:    stateNext = LATCH;
            LATCH:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Glyph lookup: printable range 0x20-0x7F maps onto 96 glyphs of 16 bytes
    always_comb begin
        charPrintable = ~charOutput[7] & (|charOutput[6:5]);
        glyph         = GlyphW'(charOutput[6:0] - 7'h20);
        fontSel       = printableQ ? fontByte : '0;
`ifdef TEXT_ENGINE_INVERT_EN
        pixelNext     = invertQ ? ~fontSel : fontSel;
`else
        pixelNext     = fontSel;
`endif
    end

    // Text row holds 16 chars; two OLED pages per text row
    assign charAddress = {addrQ[9:8], addrQ[6:3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            addrQ       <= '0;
            printableQ  <= 1'b0;
            invertQ     <= 1'b0;
            fontAddress <= '0;
            fontRead    <= 1'b0;
            pixelData   <= '0;
            pixelValid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy       <= (stateNext != IDLE);
            pixelValid <= (state == LATCH);
            fontRead   <= (state == CHAR) && charPrintable;
            if (accept) begin
                addrQ <= pixelAddress;
`ifdef TEXT_ENGINE_INVERT_EN
                invertQ <= invert;
`else
                invertQ <= 1'b0;
`endif
            end
            if (state == CHAR) begin
                printableQ  <= charPrintable;
                fontAddress <= FontAddrW'({glyph, addrQ[7], addrQ[2:0]});
            end
            if (state == LATCH) begin
                pixelData <= pixelNext;
            end
        end
    end

endmodule

// File: tb/tb_text_engine.sv
// Randomized self-checking bench for text_engine with a behavioural text/font model.
module tb_text_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        invert;
    logic [9:0]  pixelAddress;
    logic        reqValid;
    logic        busy;
    logic [5:0]  charAddress;
    logic [7:0]  charOutput;
    logic [10:0] fontAddress;
    logic        fontRead;
    logic [7:0]  fontByte;
    logic [7:0]  pixelData;
    logic        pixelValid;

    logic [7:0]  textMem [64];
    logic [7:0]  fontRom [2048];

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    text_engine dut (
        .clk          (clk),
        .rst          (rst),
`ifdef TEXT_ENGINE_INVERT_EN
        .invert       (invert),
`endif
        .pixelAddress (pixelAddress),
        .reqValid     (reqValid),
        .busy         (busy),
        .charAddress  (charAddress),
        .charOutput   (charOutput),
        .fontAddress  (fontAddress),
        .fontRead     (fontRead),
        .fontByte     (fontByte),
        .pixelData    (pixelData),
        .pixelValid   (pixelValid)
    );

    assign charOutput = textMem[charAddress];

    always @(posedge clk) begin
        if (fontRead) fontByte <= fontRom[fontAddress];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] charAt(input logic [9:0] addr);
        int page = int'(addr) / 128;
        int col  = int'(addr) % 128;
        return textMem[(page / 2) * 16 + col / 8];
    endfunction

    function automatic bit isPrintable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7F);
    endfunction

    function automatic logic [7:0] refPixel(input logic [9:0] addr, input logic inv);
        int page = int'(addr) / 128;
        int col  = int'(addr) % 128;
        int c    = int'(charAt(addr));
        logic [7:0] r;
        if (c >= 32 && c <= 127) r = fontRom[(c - 32) * 16 + (page % 2) * 8 + col % 8];
        else r = 8'h00;
        return inv ? ~r : r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; reqValid = 1'b1; invert = 1'b0;
        pixelAddress = 10'($urandom);
        step(); step();
        nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nTests++; if (pixelValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", pixelValid); end
        nTests++; if (fontRead !== 1'b0) begin nFail++; $display("FAIL reset_fontRead: got %b want 0", fontRead); end
        nTests++; if (pixelData !== 8'h00) begin nFail++; $display("FAIL reset_pixelData: got %h want 00", pixelData); end
        nTests++; if (fontAddress !== 11'd0) begin nFail++; $display("FAIL reset_fontAddress: got %0d want 0", fontAddress); end
        nTests++; if (charAddress !== 6'd0) begin nFail++; $display("FAIL reset_charAddress: got %0d want 0", charAddress); end
        rst = 1'b0; reqValid = 1'b0;
        step();
    endtask

    task automatic test_directed();
        textMem[0] = 8'h4C; fontRom[704] = 8'h7F; invert = 1'b0;
        pixelAddress = 10'h000; reqValid = 1'b1;
        step(); reqValid = 1'b0;
        nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL directed_busy_c1: got %b want 1", busy); end
        nTests++; if (charAddress !== 6'd0) begin nFail++; $display("FAIL directed_charAddress: got %0d want 0", charAddress); end
        nTests++; if (fontRead !== 1'b0) begin nFail++; $display("FAIL directed_fontRead_c1: got %b want 0", fontRead); end
        step();
        nTests++; if (fontRead !== 1'b1) begin nFail++; $display("FAIL directed_fontRead_c2: got %b want 1", fontRead); end
        nTests++; if (fontAddress !== 11'd704) begin nFail++; $display("FAIL directed_fontAddress: got %0d want 704", fontAddress); end
        step();
        nTests++; if (pixelValid !== 1'b0) begin nFail++; $display("FAIL directed_valid_c3: got %b want 0", pixelValid); end
        nTests++; if (fontRead !== 1'b0) begin nFail++; $display("FAIL directed_fontRead_c3: got %b want 0", fontRead); end
        step();
        nTests++; if (pixelValid !== 1'b1) begin nFail++; $display("FAIL directed_valid_c4: got %b want 1", pixelValid); end
        nTests++; if (pixelData !== 8'h7F) begin nFail++; $display("FAIL directed_pixelData: got %h want 7f", pixelData); end
        nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL directed_busy_c4: got %b want 0", busy); end
        step();
        nTests++; if (pixelValid !== 1'b0) begin nFail++; $display("FAIL directed_valid_c5: got %b want 0", pixelValid); end
        nTests++; if (pixelData !== 8'h7F) begin nFail++; $display("FAIL directed_hold: got %h want 7f", pixelData); end
    endtask

    task automatic test_wrap();
        textMem[63] = 8'h21; fontRom[31] = 8'hA5; invert = 1'b0;
        pixelAddress = 10'h3FF; reqValid = 1'b1;
        step(); reqValid = 1'b0;
        nTests++; if (charAddress !== 6'd63) begin nFail++; $display("FAIL wrap_charAddress: got %0d want 63", charAddress); end
        step();
        nTests++; if (fontAddress !== 11'd31) begin nFail++; $display("FAIL wrap_fontAddress: got %0d want 31", fontAddress); end
        step(); step();
        nTests++; if (pixelValid !== 1'b1) begin nFail++; $display("FAIL wrap_valid: got %b want 1", pixelValid); end
        nTests++; if (pixelData !== 8'hA5) begin nFail++; $display("FAIL wrap_pixelData: got %h want a5", pixelData); end
    endtask

    task automatic test_nonprintable();
        for (int k = 0; k < 2; k++) begin
            logic [9:0] addr = 10'($urandom);
            logic [7:0] want;
            bit sawRead = 1'b0;
            int page = int'(addr) / 128;
            int col  = int'(addr) % 128;
            textMem[(page / 2) * 16 + col / 8] = (k == 0) ? 8'h00 : 8'h80;
`ifdef TEXT_ENGINE_INVERT_EN
            invert = 1'b1; want = 8'hFF;
`else
            invert = 1'b0; want = 8'h00;
`endif
            pixelAddress = addr; reqValid = 1'b1;
            step(); reqValid = 1'b0;
            for (int i = 1; i <= 3; i++) begin
                if (fontRead) sawRead = 1'b1;
                step();
            end
            nTests++; if (sawRead !== 1'b0) begin nFail++; $display("FAIL nonprint_fontRead[%0d]: got 1 want 0", k); end
            nTests++; if (pixelValid !== 1'b1) begin nFail++; $display("FAIL nonprint_valid[%0d]: got %b want 1", k, pixelValid); end
            nTests++; if (pixelData !== want) begin nFail++; $display("FAIL nonprint_pixelData[%0d]: got %h want %h", k, pixelData, want); end
            invert = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expQ[$];
        for (int i = 0; i < 64; i++) textMem[i] = 8'($urandom_range(32, 127));
        invert = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            int cyc = c + 1;
            bit expValid;
            bit expBusy;
            reqValid = (c <= 8);
            pixelAddress = 10'($urandom);
            if (c % 4 == 0 && c <= 8) expQ.push_back(refPixel(pixelAddress, 1'b0));
            step();
            expValid = (cyc % 4 == 0) && (cyc >= 4) && (cyc <= 12);
            expBusy  = (cyc <= 11) && (cyc % 4 != 0);
            nTests++; if (pixelValid !== expValid) begin nFail++; $display("FAIL b2b_valid c%0d: got %b want %b", cyc, pixelValid, expValid); end
            nTests++; if (busy !== expBusy) begin nFail++; $display("FAIL b2b_busy c%0d: got %b want %b", cyc, busy, expBusy); end
            if (expValid) begin
                logic [7:0] w = expQ.pop_front();
                nTests++; if (pixelData !== w) begin nFail++; $display("FAIL b2b_pixelData c%0d: got %h want %h", cyc, pixelData, w); end
            end
        end
        reqValid = 1'b0;
        nTests++; if (expQ.size() != 0) begin nFail++; $display("FAIL b2b_pending: got %0d left want 0", expQ.size()); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] want;
        invert = 1'b0;
        pixelAddress = 10'($urandom); reqValid = 1'b1;
        step(); reqValid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        nTests++; if (fontRead !== 1'b0) begin nFail++; $display("FAIL rstmid_fontRead: got %b want 0", fontRead); end
        nTests++; if (pixelValid !== 1'b0) begin nFail++; $display("FAIL rstmid_valid_c3: got %b want 0", pixelValid); end
        pixelAddress = 10'($urandom); reqValid = 1'b1;
        want = refPixel(pixelAddress, 1'b0);
        step(); reqValid = 1'b0;
        nTests++; if (pixelValid !== 1'b0) begin nFail++; $display("FAIL rstmid_valid_c4: got %b want 0", pixelValid); end
        nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL rstmid_accept: got %b want 1", busy); end
        step(); step(); step();
        nTests++; if (pixelValid !== 1'b1) begin nFail++; $display("FAIL rstmid_next_valid: got %b want 1", pixelValid); end
        nTests++; if (pixelData !== want) begin nFail++; $display("FAIL rstmid_next_data: got %h want %h", pixelData, want); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) textMem[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            logic [9:0] addr;
            logic [7:0] want;
            bit printable;
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
            addr = 10'($urandom);
`ifdef TEXT_ENGINE_INVERT_EN
            invert = 1'($urandom);
`else
            invert = 1'b0;
`endif
            printable = isPrintable(charAt(addr));
            want = refPixel(addr, invert);
            pixelAddress = addr; reqValid = 1'b1;
            step();
            for (int cyc = 1; cyc <= 3; cyc++) begin
                bit expRead = (cyc == 2) && printable;
                nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL rand_busy[%0d] c%0d: got %b want 1", n, cyc, busy); end
                nTests++; if (fontRead !== expRead) begin nFail++; $display("FAIL rand_fontRead[%0d] c%0d: got %b want %b", n, cyc, fontRead, expRead); end
                reqValid = 1'($urandom);
                pixelAddress = 10'($urandom);
                invert = 1'($urandom);
                step();
            end
            reqValid = 1'b0;
            nTests++; if (pixelValid !== 1'b1) begin nFail++; $display("FAIL rand_valid[%0d]: got %b want 1", n, pixelValid); end
            nTests++; if (pixelData !== want) begin nFail++; $display("FAIL rand_pixelData[%0d] addr %h: got %h want %h", n, addr, pixelData, want); end
        end
        invert = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b0; pixelAddress = '0; invert = 1'b0;
        for (int i = 0; i < 2048; i++) fontRom[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) textMem[i] = 8'h20;
        test_reset();
        test_directed();
        test_wrap();
        test_nonprintable();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
